mult4u_share_arb: RTL and testbench
===================================

# mult4u_share_arb

Sequencer and round-robin arbiter that time-shares one combinational 4-bit unsigned multiplier between NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes, drives the shared multiplier, registers the 8-bit product and returns it with the requester ID over a single response handshake. When built with the recheck option, it re-runs every operation with the operands swapped and flags result mismatches, giving fault detection on the multiplier datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, must equal ceil(log2(NREQ))

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  bit i: requester i has an operand pair pending
- req_a  in  4*NREQ  A operand for requester i, in bits [4i+3:4i]
- req_b  in  4*NREQ  B operand for requester i, in bits [4i+3:4i]
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- mul_a  out  4  A operand driven to the shared multiplier
- mul_b  out  4  B operand driven to the shared multiplier
- mul_p  in  8  product returned by the shared multiplier
- rsp_valid  out  1  response is valid
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  IDW  requester that owns the response
- rsp_prod  out  8  product
- rsp_err  out  1  recheck mismatch; constant 0 when the recheck option is compiled out
- err_cnt  out  8  saturating count of mismatches; constant 0 when the recheck option is compiled out

## Operation
- The FSM has four states: IDLE, ISSUE, CHECK and RESP.
- **IDLE**
  - The arbiter scans req_valid starting at ptr and wrapping through NREQ-1, then 0, up to ptr-1.
  - The first asserted bit becomes grant g. req_ready is one-hot on g.
  - req_ready is all-zero when no request is pending, and in every other state.
  - On handshake, the block latches op_a = req_a[g], op_b = req_b[g] and op_id = g, then moves to ISSUE.
- **ISSUE**
  - mul_a = op_a and mul_b = op_b.
  - At the end of the cycle, mul_p is captured into prod.
  - Next state is CHECK if RECHECK is enabled, otherwise RESP.
- **CHECK**
  - mul_a = op_b and mul_b = op_a.
  - At the end of the cycle, err_r is set to (mul_p != prod).
  - If a mismatch occurs and err_cnt < 255, err_cnt increments.
  - Next state is RESP.
- **RESP**
  - rsp_valid = 1, rsp_id = op_id, rsp_prod = prod, rsp_err = err_r.
  - These outputs hold stable while rsp_ready is low.
  - On rsp_ready, the block sets ptr = (op_id+1) mod NREQ, clears err_r and returns to IDLE.
- In IDLE and RESP, mul_a and mul_b still show op_a and op_b. They are don't-care to the consumer.
- A requester must keep req_valid and its operands stable until it is granted. Dropping req_valid before grant is legal; the request is then simply not served.
- Fairness: after serving requester i, requester i has the lowest priority. No requester waits more than NREQ-1 operations.
- The product is 8 bits unsigned. It never overflows (maximum 15*15 = 225).

## Timing
- Reset values: state IDLE, ptr 0, op_a/op_b/op_id/prod/err_r 0, err_cnt 0. All outputs are 0, including req_ready, rsp_valid and mul_a/mul_b.
- Reset is asynchronous and takes effect mid-operation from any state. Any in-flight operation is dropped with no response.
- mul_p is sampled exactly one full cycle after mul_a/mul_b change. The multiplier must settle within one clock period.
- Latency, without recheck: handshake in cycle t gives rsp_valid in cycle t+2.
- Latency, with recheck: handshake in cycle t gives rsp_valid in cycle t+3.
- Throughput: at most one operation per 3 cycles without recheck and per 4 cycles with recheck, when rsp_ready is tied high.
- There are no combinational paths from req_valid to rsp_*, or from rsp_ready to req_ready.
- req_ready depends combinationally on req_valid and ptr (IDLE only).
- Simultaneous requests: all-valid with ptr=2 and NREQ=4 gives the grant order 2, 3, 0, 1.

## Configuration
- Macro: MULT4U_RECHECK_EN.
- **Defined:** the CHECK state exists, each operation runs twice with swapped operands, and rsp_err and err_cnt are live.
- **Undefined:** CHECK is removed, ISSUE goes directly to RESP, and rsp_err and err_cnt are tied to 0.

## Test plan
- **Reset:** assert rst_n=0 mid-ISSUE with req_valid=4'b0001. After release, all outputs read 0 and the next grant goes to requester 0.
- **Single op:** requester 1 sends a=13, b=11 -> rsp_prod=143, rsp_id=1, rsp_err=0. Latency is 2 cycles (3 with MULT4U_RECHECK_EN).
- **Round-robin:** all four requesters valid with a=i+1, b=15, rsp_ready held high -> responses in ID order 0, 1, 2, 3 with products 15, 30, 45, 60. Then requester 0 alone re-requests and is granted.
- **Backpressure:** hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stay stable, req_ready stays 0, and no new grant is issued until the handshake.
- **Fault injection (recheck on):** the model returns 225 for (15,15) but corrupts the swapped pass to 224 -> rsp_prod=225, rsp_err=1, err_cnt=1. Repeat 300 times -> err_cnt saturates at 255.
- **Boundary operands:** (0,15) gives 0, (15,0) gives 0, (15,15) gives 225, (1,1) gives 1, all with rsp_err=0.

Source files
------------

// File: rtl/mult4u_share_arb_if.sv
// Bundle of requester, response and shared-multiplier signals for mult4u_share_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface mult4u_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [3:0]        mul_a;
  logic [3:0]        mul_b;
  logic [7:0]        mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_prod;
  logic              rsp_err;
  logic [7:0]        err_cnt;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, rsp_err, err_cnt
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, rsp_err, err_cnt
  );
endinterface

// File: rtl/mult4u_share_arb.sv
// Round-robin sequencer sharing one combinational 4x4 unsigned multiplier among NREQ requesters.
// Optional MULT4U_RECHECK_EN re-runs each product with swapped operands and flags mismatches.
module mult4u_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult4u_share_arb_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, op_id, gid;
  logic [3:0]     op_a, op_b;
  logic [7:0]     prod;
  logic           found, hs;
  logic [NREQ-1:0] grant;

  // Scan req_valid from ptr upward with wrap; the first hit wins.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gid   = IDW'(idx);
      end
    end
    if (found) grant = NREQ'(1) << gid;
  end

  assign hs = (state == IDLE) && found;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (hs) state_nxt = ISSUE;
`ifdef MULT4U_RECHECK_EN
      ISSUE: state_nxt = CHECK;
      CHECK: state_nxt = RESP;
`else
      ISSUE: state_nxt = RESP;
`endif
      RESP:  if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: asynchronous reset in the sensitivity list; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_id <= '0;
      prod  <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_a  <= bus.req_a[4*gid +: 4];
        op_b  <= bus.req_b[4*gid +: 4];
        op_id <= gid;
      end
      if (state == ISSUE) prod <= bus.mul_p;
      if (state == RESP && bus.rsp_ready) ptr <= IDW'((int'(op_id) + 1) % NREQ);
    end
  end

`ifdef MULT4U_RECHECK_EN
  logic       err_r;
  logic [7:0] err_cnt_r;
  logic       mismatch;

  assign mismatch = (bus.mul_p != prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r     <= 1'b0;
      err_cnt_r <= '0;
    end else if (state == CHECK) begin
      err_r <= mismatch;
      if (mismatch && err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
    end else if (state == RESP && bus.rsp_ready) begin
      err_r <= 1'b0;
    end
  end

  assign bus.rsp_err = err_r;
  assign bus.err_cnt = err_cnt_r;
  // The swapped pass feeds B on the A port and vice versa.
  assign bus.mul_a   = (state == CHECK) ? op_b : op_a;
  assign bus.mul_b   = (state == CHECK) ? op_a : op_b;
`else
  assign bus.rsp_err = 1'b0;
  assign bus.err_cnt = 8'd0;
  assign bus.mul_a   = op_a;
  assign bus.mul_b   = op_b;
`endif

  assign bus.req_ready = (state == IDLE) ? grant : '0;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = op_id;
  assign bus.rsp_prod  = prod;

endmodule

// File: tb/tb_mult4u_share_arb.sv
// Directed bench for mult4u_share_arb; models the shared multiplier with an optional fault on
// the second (swapped) pass so the recheck path can be exercised when MULT4U_RECHECK_EN is set.
module tb_mult4u_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef MULT4U_RECHECK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic fault_en;
  logic [3:0] phase;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  int         got_id [NREQ];
  logic [7:0] got_p  [NREQ];
  int         got_cyc[NREQ];
  int         got_n;

  mult4u_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  mult4u_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycles since the last grant: 1 = first multiplier pass, 2 = swapped pass.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= '0;
    else if (|(bus.req_valid & bus.req_ready)) phase <= 4'd1;
    else if (phase != 4'd0 && phase != 4'd15) phase <= phase + 4'd1;
  end

  assign bus.mul_p = ({4'b0, bus.mul_a} * {4'b0, bus.mul_b}) -
                     {7'b0, (fault_en && phase == 4'd2)};

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Requester id presents (a,b), is granted, then the response is collected with rsp_ready high.
  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                        output logic [7:0] p, output logic [IDW-1:0] rid,
                        output logic e, output int lat);
    int n;
    p = '0; rid = '0; e = 1'b0; lat = -1;
    bus.req_a[4*id +: 4] = a;
    bus.req_b[4*id +: 4] = b;
    bus.req_valid[id]    = 1'b1;
    bus.rsp_ready        = 1'b1;
    n = 0;
    while (!bus.req_ready[id] && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready[id]) begin
      total++; bad++;
      $display("FAIL grant_timeout id=%0d got no grant, required grant within 50 cycles", id);
      bus.req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_timeout id=%0d got no rsp_valid, required within 50 cycles", id);
      return;
    end
    lat = n; p = bus.rsp_prod; rid = bus.rsp_id; e = bus.rsp_err;
    @(posedge clk); #1;
  endtask

  // All currently valid requesters are served; each drops valid right after its grant.
  task automatic collect_all();
    logic [NREQ-1:0] hs;
    got_n = 0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 80 && got_n < NREQ; n++) begin
      hs = bus.req_valid & bus.req_ready;
      if (bus.rsp_valid) begin
        got_id[got_n]  = int'(bus.rsp_id);
        got_p[got_n]   = bus.rsp_prod;
        got_cyc[got_n] = cyc;
        got_n++;
      end
      if (got_n < NREQ) begin
        @(posedge clk); #1;
        bus.req_valid = bus.req_valid & ~hs;
      end
    end
    total++;
    if (got_n !== NREQ) begin
      bad++;
      $display("FAIL collect_count got=%0d required=%0d", got_n, NREQ);
    end
  endtask

  task automatic test_reset();
    logic [7:0] p; logic [IDW-1:0] rid; logic e; int lat;
    int n;
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    fault_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, bus.rsp_err, bus.err_cnt,
         bus.mul_a, bus.mul_b} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b vld=%b id=%0d prod=%0d err=%b cnt=%0d ma=%0d mb=%0d, required all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, bus.rsp_err, bus.err_cnt,
               bus.mul_a, bus.mul_b);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Serve requester 2 so ptr moves to 3 before the mid-operation reset.
    run_op(2, 4'd5, 4'd3, p, rid, e, lat);
    total++;
    if (p !== 8'd15 || rid !== 2'd2) begin
      bad++; $display("FAIL pre_reset_op got prod=%0d id=%0d, required prod=15 id=2", p, rid);
    end

    bus.req_a[3:0] = 4'd9; bus.req_b[3:0] = 4'd9; bus.req_valid = 4'b0001;
    n = 0;
    while (!bus.req_ready[0] && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;       // now in the first multiplier pass
    bus.req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.mul_a !== 4'd0 || bus.mul_b !== 4'd0 || bus.req_ready !== '0) begin
      bad++;
      $display("FAIL mid_reset got vld=%b ma=%0d mb=%0d rdy=%b, required 0 0 0 0000",
               bus.rsp_valid, bus.mul_a, bus.mul_b, bus.req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_a = 16'h4321; bus.req_b = 16'h1111; bus.req_valid = 4'b1111;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 1'b0 || bus.rsp_prod !== 8'd0) begin
      bad++;
      $display("FAIL post_reset_grant got rdy=%b vld=%b prod=%0d, required rdy=0001 vld=0 prod=0",
               bus.req_ready, bus.rsp_valid, bus.rsp_prod);
    end
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL dropped_op got rsp_valid=%b, required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_single();
    logic [7:0] p; logic [IDW-1:0] rid; logic e; int lat;
    run_op(1, 4'd13, 4'd11, p, rid, e, lat);
    total++;
    if (p !== 8'd143 || rid !== 2'd1 || e !== 1'b0) begin
      bad++; $display("FAIL single_op got prod=%0d id=%0d err=%b, required 143 1 0", p, rid, e);
    end
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL single_latency got=%0d required=%0d", lat, LAT);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] p; logic [IDW-1:0] rid; logic e; int lat;
    logic [3:0] va [4] = '{4'd0, 4'd15, 4'd15, 4'd1};
    logic [3:0] vb [4] = '{4'd15, 4'd0, 4'd15, 4'd1};
    logic [7:0] vp [4] = '{8'd0, 8'd0, 8'd225, 8'd1};
    for (int i = 0; i < 4; i++) begin
      run_op(3, va[i], vb[i], p, rid, e, lat);
      total++;
      if (p !== vp[i] || rid !== 2'd3 || e !== 1'b0) begin
        bad++;
        $display("FAIL boundary_%0d (%0d,%0d) got prod=%0d id=%0d err=%b, required %0d 3 0",
                 i, va[i], vb[i], p, rid, e, vp[i]);
      end
    end
    total++;
    if (bus.err_cnt !== 8'd0) begin
      bad++; $display("FAIL boundary_err_cnt got=%0d required=0", bus.err_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] p; logic [IDW-1:0] rid; logic e; int lat;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[4*i +: 4] = 4'(i + 1);
      bus.req_b[4*i +: 4] = 4'd15;
    end
    bus.req_valid = 4'b1111;
    collect_all();
    for (int i = 0; i < got_n; i++) begin
      total++;
      if (got_id[i] !== i || got_p[i] !== 8'(15 * (i + 1))) begin
        bad++;
        $display("FAIL rr_resp_%0d got id=%0d prod=%0d, required id=%0d prod=%0d",
                 i, got_id[i], got_p[i], i, 15 * (i + 1));
      end
      if (i > 0) begin
        total++;
        if (got_cyc[i] - got_cyc[i-1] !== LAT + 1) begin
          bad++;
          $display("FAIL rr_spacing_%0d got=%0d cycles required=%0d", i,
                   got_cyc[i] - got_cyc[i-1], LAT + 1);
        end
      end
    end
    run_op(0, 4'd4, 4'd4, p, rid, e, lat);
    total++;
    if (p !== 8'd16 || rid !== 2'd0) begin
      bad++; $display("FAIL rr_rerequest got prod=%0d id=%0d, required 16 0", p, rid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.rsp_ready = 1'b0;
    bus.req_a[3:0] = 4'd2; bus.req_b[3:0] = 4'd3;
    bus.req_a[7:4] = 4'd7; bus.req_b[7:4] = 4'd9;
    bus.req_valid = 4'b0011;
    #1;
    total++;
    if (bus.req_ready !== 4'b0010) begin
      bad++; $display("FAIL bp_first_grant got rdy=%b required=0010", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_prod !== 8'd63 ||
          bus.req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold_%0d got vld=%b id=%0d prod=%0d rdy=%b, required 1 1 63 0000",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, bus.req_ready);
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL bp_release got vld=%b rdy=%b, required vld=0 rdy=0001", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_prod !== 8'd6) begin
      bad++;
      $display("FAIL bp_second got vld=%b id=%0d prod=%0d, required 1 0 6", bus.rsp_valid, bus.rsp_id, bus.rsp_prod);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] p; logic [IDW-1:0] rid; logic e; int lat;
    int exp_id [4] = '{2, 3, 0, 1};
    // Serving requester 1 leaves ptr at 2.
    run_op(1, 4'd1, 4'd2, p, rid, e, lat);
    total++;
    if (p !== 8'd2 || rid !== 2'd1) begin
      bad++; $display("FAIL b2b_setup got prod=%0d id=%0d, required 2 1", p, rid);
    end
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[4*i +: 4] = 4'(i + 1);
      bus.req_b[4*i +: 4] = 4'(i + 2);
    end
    bus.req_valid = 4'b1111;
    collect_all();
    for (int i = 0; i < got_n; i++) begin
      total++;
      if (got_id[i] !== exp_id[i] || got_p[i] !== 8'((exp_id[i] + 1) * (exp_id[i] + 2))) begin
        bad++;
        $display("FAIL b2b_order_%0d got id=%0d prod=%0d, required id=%0d prod=%0d", i,
                 got_id[i], got_p[i], exp_id[i], (exp_id[i] + 1) * (exp_id[i] + 2));
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef MULT4U_RECHECK_EN
  task automatic test_recheck();
    logic [7:0] p; logic [IDW-1:0] rid; logic e; int lat;
    fault_en = 1'b1;
    run_op(0, 4'd15, 4'd15, p, rid, e, lat);
    total++;
    if (p !== 8'd225 || e !== 1'b1 || bus.err_cnt !== 8'd1) begin
      bad++;
      $display("FAIL fault_first got prod=%0d err=%b cnt=%0d, required 225 1 1", p, e, bus.err_cnt);
    end
    for (int i = 1; i < 300; i++) run_op(0, 4'd15, 4'd15, p, rid, e, lat);
    total++;
    if (bus.err_cnt !== 8'd255 || e !== 1'b1) begin
      bad++; $display("FAIL fault_saturate got cnt=%0d err=%b, required 255 1", bus.err_cnt, e);
    end
    fault_en = 1'b0;
    run_op(2, 4'd3, 4'd5, p, rid, e, lat);
    total++;
    if (p !== 8'd15 || e !== 1'b0 || bus.err_cnt !== 8'd255) begin
      bad++;
      $display("FAIL fault_clear got prod=%0d err=%b cnt=%0d, required 15 0 255", p, e, bus.err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
`ifdef MULT4U_RECHECK_EN
    test_recheck();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
